locked_stat_sequencer: RTL and testbench

Controller that drives the 32-input / 128-key / 22-output logic-locked core for the statistical key-recovery flow. It holds one candidate key on the core's key pins and applies a run of LFSR-generated input patterns, waiting a programmable settle time before each capture. For every pattern it captures the 22 output bits, streams them out over a valid/ready port and accumulates a per-output-bit ones count. It sits between the attack host interface and the locked core, so that a whole key candidate is evaluated without host intervention per pattern.

---
 rtl/locked_stat_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_locked_stat_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_stat_sequencer.sv
// locked_stat_sequencer
//   Drives one candidate key onto the logic-locked core and applies a run of
//   LFSR patterns. After a programmable settle time each 22-bit response is
//   captured, offered on a valid/ready port and added into per-bit ones
//   counters (saturating), so a whole key candidate is scored without host
//   involvement per pattern.
//
// Ports
//   v_in1_v        clock, rising edge
//   reset          synchronous active-high reset
//   start          run request, only looked at in IDLE
//   num_patterns   patterns per run, latched on start
//   seed           LFSR seed, latched on start (0 is replaced by 1)
//   key_in         candidate key, latched on start
//   dut_in         core data inputs (bit 31 = v_in2)
//   dut_key        core key inputs (bit 127 = keyinput_0)
//   dut_out        core outputs (bit 21 = o1)
//   cap_valid      captured word available
//   cap_ready      consumer accepts cap_data
//   cap_data       captured dut_out
//   busy           high outside IDLE
//   done           one-cycle pulse at end of run
//   ones_cnt       per-bit ones counts, [i*CNT_W +: CNT_W] is dut_out[i]
//
// PAT_W sizes the pattern counter and num_patterns; it defaults to CNT_W and
// only needs overriding when the ones counters are made narrower than the run
// length (e.g. to exercise counter saturation).
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for start, outputs hold
// ST_LOAD    | put current LFSR value on dut_in
// ST_SETTLE  | wait for the core outputs to settle
// ST_CAPTURE | capture dut_out, update ones counters
// ST_DRAIN   | offer cap_data until the consumer takes it
// ST_DONE    | done pulse, back to IDLE

module locked_stat_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16,
    parameter int PAT_W  = CNT_W
) (
    input  logic                  v_in1_v,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PAT_W-1:0]      num_patterns,
    input  logic [31:0]           seed,
    input  logic [127:0]          key_in,
    output logic [31:0]           dut_in,
    output logic [127:0]          dut_key,
    input  logic [21:0]           dut_out,
    output logic                  cap_valid,
    input  logic                  cap_ready,
    output logic [21:0]           cap_data,
    output logic                  busy,
    output logic                  done,
    output logic [22*CNT_W-1:0]   ones_cnt
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                      state_q;
    logic [31:0]                 dut_in_q;
    logic [127:0]                dut_key_q;
    logic                        cap_valid_q;
    logic [21:0]                 cap_data_q;
    logic                        busy_q;
    logic                        done_q;
    logic [21:0][CNT_W-1:0]      ones_q;
    logic [21:0][CNT_W-1:0]      ones_d;
    logic [31:0]                 lfsr_q;
    logic [31:0]                 lfsr_d;
    logic [PAT_W-1:0]            pat_cnt_q;
    logic [PAT_W-1:0]            pat_inc;
    logic [PAT_W-1:0]            npat_q;
    logic [SW-1:0]               settle_q;

    // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting towards the MSB
    assign lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign pat_inc = pat_cnt_q + 1'b1;

    // Saturating per-bit increment, applied only in CAPTURE
    always_comb begin
        ones_d = ones_q;
        for (int i = 0; i < 22; i++) begin
            if (dut_out[i] && (ones_q[i] != {CNT_W{1'b1}})) begin
                ones_d[i] = ones_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge v_in1_v) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dut_in_q    <= '0;
            dut_key_q   <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ones_q      <= '0;
            lfsr_q      <= 32'd1;
            pat_cnt_q   <= '0;
            npat_q      <= '0;
            settle_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dut_key_q <= key_in;
                        lfsr_q    <= (seed == 32'd0) ? 32'd1 : seed;
                        pat_cnt_q <= '0;
                        ones_q    <= '0;
                        npat_q    <= num_patterns;
                        busy_q    <= 1'b1;
                        if (num_patterns == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    dut_in_q <= lfsr_q;
                    settle_q <= SW'(SETTLE - 1);
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    cap_data_q  <= dut_out;
                    cap_valid_q <= 1'b1;
                    ones_q      <= ones_d;
                    state_q     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // cap_valid is always high here, so only cap_ready gates progress
                    if (cap_ready) begin
                        cap_valid_q <= 1'b0;
                        pat_cnt_q   <= pat_inc;
                        lfsr_q      <= lfsr_d;
                        if (pat_inc == npat_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dut_in    = dut_in_q;
    assign dut_key   = dut_key_q;
    assign cap_valid = cap_valid_q;
    assign cap_data  = cap_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_locked_stat_sequencer.sv
// Bench for locked_stat_sequencer. The main instance sees a core model that
// echoes dut_in[21:0]; a second, narrow-counter instance sees an all-ones
// core to exercise saturation.
module tb_locked_stat_sequencer;

    logic          v_in1_v;
    logic          reset;
    logic          start;
    logic [15:0]   num_patterns;
    logic [31:0]   seed;
    logic [127:0]  key_in;
    logic [31:0]   dut_in;
    logic [127:0]  dut_key;
    logic [21:0]   dut_out;
    logic          cap_valid;
    logic          cap_ready;
    logic [21:0]   cap_data;
    logic          busy;
    logic          done;
    logic [351:0]  ones_cnt;

    logic          s_start;
    logic [7:0]    s_npat;
    logic [31:0]   s_seed;
    logic [127:0]  s_key;
    logic [31:0]   s_dut_in;
    logic [127:0]  s_dut_key;
    logic [21:0]   s_dut_out;
    logic          s_valid;
    logic          s_ready;
    logic [21:0]   s_data;
    logic          s_busy;
    logic          s_done;
    logic [87:0]   s_ones;

    int n_vec = 0;
    int n_err = 0;

    assign dut_out   = dut_in[21:0];
    assign s_dut_out = 22'h3FFFFF;

    locked_stat_sequencer #(.SETTLE(2), .CNT_W(16)) u_dut (
        .v_in1_v(v_in1_v), .reset(reset), .start(start),
        .num_patterns(num_patterns), .seed(seed), .key_in(key_in),
        .dut_in(dut_in), .dut_key(dut_key), .dut_out(dut_out),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
        .busy(busy), .done(done), .ones_cnt(ones_cnt)
    );

    locked_stat_sequencer #(.SETTLE(2), .CNT_W(4), .PAT_W(8)) u_sat (
        .v_in1_v(v_in1_v), .reset(reset), .start(s_start),
        .num_patterns(s_npat), .seed(s_seed), .key_in(s_key),
        .dut_in(s_dut_in), .dut_key(s_dut_key), .dut_out(s_dut_out),
        .cap_valid(s_valid), .cap_ready(s_ready), .cap_data(s_data),
        .busy(s_busy), .done(s_done), .ones_cnt(s_ones)
    );

    initial v_in1_v = 1'b0;
    always #5 v_in1_v = ~v_in1_v;

    typedef struct {
        logic [15:0]       npat;
        logic [31:0]       seed;
        logic [127:0]      key;
        logic [2:0][31:0]  exp_in;     // expected dut_in per pattern
        int                lo_len;     // cap_ready low cycles at first cap_valid
        int                busy_start; // cycle to pulse a stray start (0 = none)
        int                exp_done;
        logic [31:0]       last_in;    // dut_in expected to hold after the run
    } vec_t;

    function automatic vec_t mk(input logic [15:0] np, input logic [31:0] sd,
                                input logic [127:0] k, input logic [31:0] i0,
                                input logic [31:0] i1, input logic [31:0] i2,
                                input int lo, input int bs, input int dn,
                                input logic [31:0] last);
        vec_t v;
        v.npat = np; v.seed = sd; v.key = k;
        v.exp_in[0] = i0; v.exp_in[1] = i1; v.exp_in[2] = i2;
        v.lo_len = lo; v.busy_start = bs; v.exp_done = dn; v.last_in = last;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge v_in1_v);
        #1;
    endtask

    // One run on u_dut. Cycle numbering: the start edge is cycle 0, and after
    // the k-th tick the bench observes cycle k.
    task automatic run_case(input vec_t v);
        int cyc;
        int n;
        int done_cyc;
        logic prev_v;
        logic [31:0] e;
        logic [21:0][15:0] exp_ones;

        exp_ones = '0;
        for (int p = 0; p < 3; p++) begin
            if (p < int'(v.npat)) begin
                for (int i = 0; i < 22; i++) exp_ones[i] = exp_ones[i] + 16'(v.exp_in[p][i]);
            end
        end

        num_patterns = v.npat;
        seed         = v.seed;
        key_in       = v.key;
        cap_ready    = 1'b1;
        start        = 1'b1;
        tick();
        cyc   = 1;
        start = 1'b0;
        check("busy_rise", busy, 1'b1);

        done_cyc = -1;
        n        = 0;
        prev_v   = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            e = (n < 3) ? v.exp_in[n] : 32'hDEAD_BEEF;
            if (cyc == 2 && v.npat != 0) check("first_dut_in", dut_in, v.exp_in[0]);
            if (cap_valid) begin
                if (!prev_v) check("cap_cycle", cyc, 5 + 5*n + ((n > 0) ? v.lo_len : 0));
                check("cap_data", cap_data, e[21:0]);
                check("dut_in_hold", dut_in, e);
            end
            if (done) done_cyc = cyc;
            cap_ready = !(v.lo_len > 0 && cyc >= 5 && cyc < 5 + v.lo_len);
            if (cyc == v.busy_start) begin
                start        = 1'b1;
                num_patterns = 16'd0;
                key_in       = ~v.key;
                seed         = 32'hFFFF;
            end else begin
                start        = 1'b0;
                num_patterns = v.npat;
                key_in       = v.key;
                seed         = v.seed;
            end
            if (cap_valid && cap_ready) n++;
            prev_v = cap_valid;
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        if (done_cyc < 0) check("done_timeout", 1'b0, 1'b1);
        check("done_cycle", done_cyc, v.exp_done);
        check("pattern_count", n, int'(v.npat));

        start     = 1'b0;
        cap_ready = 1'b1;
        tick();
        check("busy_fall", busy, 1'b0);
        check("done_pulse_end", done, 1'b0);
        tick();
        tick();
        check("ones_cnt", ones_cnt, exp_ones);
        check("dut_key", dut_key, v.key);
        check("dut_in_after", dut_in, v.last_in);
        check("cap_valid_idle", cap_valid, 1'b0);
    endtask

    vec_t tbl [7];

    initial begin
        int cyc;
        int ncap;
        int ndone;
        int dcyc;
        logic seen;

        // LFSR from seed 1: feedback from 0x3 is 0, so the third pattern is 0x6
        tbl[0] = mk(16'd1, 32'd1, {16{8'hA5}}, 32'h1, 32'h0, 32'h0, 0, 0, 6, 32'h1);
        tbl[1] = mk(16'd3, 32'd1, 128'h0123456789ABCDEF_FEDCBA9876543210,
                    32'h1, 32'h3, 32'h6, 0, 0, 16, 32'h6);
        tbl[2] = mk(16'd0, 32'd5, 128'h1, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h6);
        tbl[3] = mk(16'd1, 32'd0, {128{1'b1}}, 32'h1, 32'h0, 32'h0, 0, 0, 6, 32'h1);
        tbl[4] = mk(16'd2, 32'h0030_0000, {16{8'h3C}}, 32'h0030_0000, 32'h0060_0001,
                    32'h0, 0, 0, 11, 32'h0060_0001);
        tbl[5] = mk(16'd2, 32'd1, {16{8'h5A}}, 32'h1, 32'h3, 32'h0, 5, 7, 16, 32'h3);
        tbl[6] = mk(16'd2, 32'd5, 128'hCAFE, 32'h5, 32'hB, 32'h0, 0, 0, 11, 32'hB);

        reset        = 1'b1;
        start        = 1'b1;
        num_patterns = 16'd3;
        seed         = 32'd1;
        key_in       = {16{8'hA5}};
        cap_ready    = 1'b1;
        s_start      = 1'b0;
        s_npat       = 8'd0;
        s_seed       = 32'd1;
        s_key        = '0;
        s_ready      = 1'b1;

        // Reset held 3 cycles with start pulsed
        tick(); tick(); tick();
        check("rst_dut_in", dut_in, 32'd0);
        check("rst_dut_key", dut_key, 128'd0);
        check("rst_cap_valid", cap_valid, 1'b0);
        check("rst_cap_data", cap_data, 22'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ones", ones_cnt, 352'd0);
        check("rst_sat_ones", s_ones, 88'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("start_in_reset_ignored", busy, 1'b0);

        // Reset in the middle of a run, with a capture pending
        num_patterns = 16'd5;
        seed         = 32'd1;
        key_in       = {16{8'hA5}};
        cap_ready    = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        check("midrun_valid_before", cap_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        cap_ready = 1'b1;
        check("midrun_cap_valid", cap_valid, 1'b0);
        check("midrun_busy", busy, 1'b0);
        check("midrun_dut_in", dut_in, 32'd0);
        check("midrun_dut_key", dut_key, 128'd0);
        check("midrun_ones", ones_cnt, 352'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check("midrun_no_done", seen, 1'b0);

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Saturation on the 4-bit-counter instance, 20 all-ones patterns
        s_npat  = 8'd20;
        s_seed  = 32'd1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cyc   = 1;
        ncap  = 0;
        ndone = 0;
        dcyc  = -1;
        while (cyc < 140) begin
            if (s_valid) ncap++;
            if (s_done) begin
                ndone++;
                dcyc = cyc;
            end
            tick();
            cyc++;
        end
        check("sat_caps", ncap, 20);
        check("sat_done_count", ndone, 1);
        check("sat_done_cycle", dcyc, 101);
        check("sat_ones", s_ones, {88{1'b1}});
        check("sat_busy_end", s_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
